// File: rtl/sumador_serial_if.sv
// Handshake and result bus of the bit-serial adder.
// The master drives the request and operands; the slave (the adder) returns status and result.
interface sumador_serial_if #(
  parameter int unsigned WIDTH = 3
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic [6:0]       seg;

  modport master (
    output start, A, B, Cin,
    input  busy, done, S, Cout, seg
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, S, Cout, seg
  );
endinterface

// File: rtl/sumador_serial.sv
// Bit-serial WIDTH-bit adder with carry-in/carry-out, one bit per clock, LSB first.
// Keeps the last completed result and drives its active-low hex 7-segment pattern.
module sumador_serial #(
  parameter int unsigned WIDTH = 3
) (
  input logic             clk,
  input logic             rst_n,
  sumador_serial_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic [6:0]       seg_q, seg_d;
  logic             sum_bit;
  logic             last_bit;
  logic [3:0]       nib;

  // Active-low gfedcba hex decode.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Full-adder step on the current LSBs plus the shifted register images.
  always_comb begin
    sum_bit  = a_q[0] ^ b_q[0] ^ c_q;
    c_d      = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    a_d      = a_q >> 1;
    b_d      = b_q >> 1;
    res_d    = (res_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
    last_bit = (cnt_q == CW'(WIDTH - 1));
    // Size cast truncates or zero-extends {Cout,S} to the low nibble for any WIDTH.
    nib      = 4'({c_d, res_d});
    seg_d    = hex7(nib);
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      seg_q   <= 7'b1000000;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            c_q     <= bus.Cin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_d;
          b_q   <= b_d;
          c_q   <= c_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            s_q     <= res_d;
            cout_q  <= c_d;
            seg_q   <= seg_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.seg  = seg_q;

endmodule

// File: tb/tb_sumador_serial.sv
// Directed and random bench for sumador_serial against an arithmetic reference model.
module tb_sumador_serial;

  localparam int W = 3;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [6:0] seg_tab [16];
  logic [W-1:0] exp_S;
  logic         exp_C;
  logic [6:0]   exp_seg;

  sumador_serial_if #(.WIDTH(W)) bus ();

  sumador_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_result(input string tag);
    chk({tag, ".S"}, 32'(bus.S), 32'(exp_S));
    chk({tag, ".Cout"}, 32'(bus.Cout), 32'(exp_C));
    chk({tag, ".seg"}, 32'(bus.seg), 32'(exp_seg));
  endtask

  // Reference: {Cout,S} = A + B + Cin modulo 2^(W+1); display shows its low nibble.
  task automatic model(input int a, input int b, input int c,
                       output logic [W-1:0] s, output logic co, output logic [6:0] sg);
    int v;
    v  = (a + b + c) % (1 << (W + 1));
    s  = W'(v % (1 << W));
    co = 1'(v >> W);
    sg = seg_tab[v & 15];
  endtask

  // One operation; poke re-asserts start and changes operands while running.
  task automatic do_op(input int a, input int b, input int c, input bit poke, input string tag);
    logic [W-1:0] ns;
    logic         nc;
    logic [6:0]   nsg;
    model(a, b, c, ns, nc, nsg);
    @(negedge clk);
    bus.A = W'(a); bus.B = W'(b); bus.Cin = 1'(c); bus.start = 1'b1;
    @(negedge clk);
    bus.start = poke;
    bus.A   = poke ? W'(1) : W'($urandom);
    bus.B   = W'($urandom);
    bus.Cin = 1'($urandom);
    chk({tag, ".busy0"}, 32'(bus.busy), 32'd1);
    chk({tag, ".done0"}, 32'(bus.done), 32'd0);
    chk_result({tag, ".hold0"});
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, ".busyR"}, 32'(bus.busy), 32'd1);
      chk({tag, ".doneR"}, 32'(bus.done), 32'd0);
      chk_result({tag, ".holdR"});
    end
    @(negedge clk);
    bus.start = 1'b0;
    exp_S = ns; exp_C = nc; exp_seg = nsg;
    chk({tag, ".doneD"}, 32'(bus.done), 32'd1);
    chk({tag, ".busyD"}, 32'(bus.busy), 32'd1);
    chk_result({tag, ".res"});
    @(negedge clk);
    chk({tag, ".doneI"}, 32'(bus.done), 32'd0);
    chk({tag, ".busyI"}, 32'(bus.busy), 32'd0);
    chk_result({tag, ".keep"});
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    exp_S = '0; exp_C = 1'b0; exp_seg = 7'b1000000;

    // Reset state, then idle with no start.
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk_result("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle.busy", 32'(bus.busy), 32'd0);
    chk("idle.done", 32'(bus.done), 32'd0);
    chk_result("idle");

    // Directed operations.
    do_op(0, 0, 1, 1'b0, "cin_only");
    do_op(3, 2, 0, 1'b0, "3p2");
    do_op(7, 7, 1, 1'b0, "7p7p1");
    do_op(4, 3, 0, 1'b1, "ignore_start");

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus.A = 3'd6; bus.B = 3'd5; bus.Cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_S = '0; exp_C = 1'b0; exp_seg = 7'b1000000;
    chk("arst.busy", 32'(bus.busy), 32'd0);
    chk("arst.done", 32'(bus.done), 32'd0);
    chk_result("arst");
    @(negedge clk);
    chk("arst2.done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst3.done", 32'(bus.done), 32'd0);
    chk_result("arst3");
    do_op(6, 5, 0, 1'b0, "after_rst");

    // start held high: back-to-back operations every W+2 cycles.
    @(negedge clk);
    bus.A = 3'd1; bus.B = 3'd1; bus.Cin = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 3 * (W + 2); c++) begin
      @(negedge clk);
      if (c == 3 * (W + 2)) bus.start = 1'b0;
      if (c >= W + 1) begin
        exp_S = 3'd2; exp_C = 1'b0; exp_seg = seg_tab[2];
      end
      chk("held.done", 32'(bus.done), 32'(c % (W + 2) == W + 1));
      chk("held.busy", 32'(bus.busy), 32'(c % (W + 2) != 0));
      chk_result("held");
    end
    repeat (2) @(negedge clk);
    chk("held_end.busy", 32'(bus.busy), 32'd0);

    // Random operations.
    for (int n = 0; n < 20; n++) begin
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), 1'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
